wb_mem_access: RTL and testbench

//  Wishbone master between the core's load/store path and the word-addressed RAM slave.
//  - Splits byte/half/word/dword accesses onto 64-bit bus words.
//  - Stores narrower than 64 bits use a read-modify-write, because the slave ignores adr[2:0].
//  - Each bus cycle is closed by dropping stb before the next one starts.
//  - A watchdog turns a hung slave into an error response.

---
 rtl/wb_mem_access.sv | 190 +++++++++++++++++++
 tb/tb_wb_mem_access.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_access.sv
// Wishbone master that maps byte/half/word/dword load-store requests onto 64-bit bus words.
// Define MEM_ACCESS_SIGN_EXT_EN to sign-extend loads flagged with req_signed_i.
module wb_mem_access #(
  parameter int ADR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_signed_i,
  input  logic [ADR_WIDTH-1:0] req_adr_i,
  input  logic [63:0]          req_dat_i,
  output logic                 resp_valid_o,
  output logic [63:0]          resp_dat_o,
  output logic                 resp_err_o,
  output logic [ADR_WIDTH-1:0] mem_adr_o,
  output logic [63:0]          mem_dat_o,
  input  logic [63:0]          mem_dat_i,
  output logic                 mem_we_o,
  output logic                 mem_stb_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_err_i
);

`ifdef MEM_ACCESS_SIGN_EXT_EN
  localparam bit SIGN_EXT = 1'b1;
`else
  localparam bit SIGN_EXT = 1'b0;
`endif

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {IDLE, BUS_R, GAP, BUS_A, RESP} state_t;

  state_t                 state_q;
  logic [WD_W-1:0]        wdog_q;
  logic                   we_q;
  logic [1:0]             size_q;
  logic                   signed_q;
  logic [ADR_WIDTH-1:0]   adr_q;
  logic [63:0]            dat_q;
  logic [63:0]            rmw_q;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
    case (size)
      2'd1:    return lane[0];
      2'd2:    return |lane[1:0];
      2'd3:    return |lane;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  function automatic logic [63:0] rmw_merge(input logic [63:0] old, input logic [63:0] dat,
                                            input logic [1:0] size, input logic [2:0] lane);
    logic [63:0] sh;
    logic [7:0]  m;
    logic [63:0] r;
    sh = dat << {lane, 3'b000};
    m  = byte_mask(size, lane);
    r  = old;
    for (int i = 0; i < 8; i++)
      if (m[i]) r[8*i +: 8] = sh[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] word, input logic [1:0] size,
                                               input logic [2:0] lane, input logic sgn);
    logic [63:0] sh;
    logic [63:0] r;
    logic        ext;
    sh  = word >> {lane, 3'b000};
    ext = SIGN_EXT && sgn;
    case (size)
      2'd0:    r = {{56{ext & sh[7]}},  sh[7:0]};
      2'd1:    r = {{48{ext & sh[15]}}, sh[15:0]};
      2'd2:    r = {{32{ext & sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  // Request latch and read-modify-write buffer: data only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (req_valid_i && req_ready_o) begin
      we_q     <= req_we_i;
      size_q   <= req_size_i;
      signed_q <= req_signed_i;
      adr_q    <= req_adr_i;
      dat_q    <= req_dat_i;
    end
    if (state_q == BUS_R && mem_ack_i && !mem_err_i)
      rmw_q <= mem_dat_i;
  end

  // Control FSM with registered bus and response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_dat_o   <= '0;
      resp_err_o   <= 1'b0;
      mem_adr_o    <= '0;
      mem_dat_o    <= '0;
      mem_we_o     <= 1'b0;
      mem_stb_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            wdog_q      <= '0;
            mem_adr_o   <= {req_adr_i[ADR_WIDTH-1:3], 3'b000};
            if (misaligned(req_size_i, req_adr_i[2:0])) begin
              state_q      <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_dat_o   <= '0;
            end else if (!req_we_i || req_size_i == 2'd3) begin
              state_q   <= BUS_A;
              mem_stb_o <= 1'b1;
              mem_we_o  <= req_we_i;
              mem_dat_o <= req_we_i ? req_dat_i : 64'd0;
            end else begin
              state_q   <= BUS_R;
              mem_stb_o <= 1'b1;
              mem_we_o  <= 1'b0;
            end
          end
        end
        BUS_R, BUS_A: begin
          if (mem_err_i || (WD_EN && !mem_ack_i && wdog_q == WD_LAST)) begin
            state_q      <= RESP;
            mem_stb_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_dat_o   <= '0;
          end else if (mem_ack_i) begin
            mem_stb_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (state_q == BUS_R) begin
              state_q <= GAP;
            end else begin
              state_q      <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b0;
              resp_dat_o   <= we_q ? 64'd0 : load_extract(mem_dat_i, size_q, adr_q[2:0], signed_q);
            end
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        GAP: begin
          state_q   <= BUS_A;
          wdog_q    <= '0;
          mem_stb_o <= 1'b1;
          mem_we_o  <= 1'b1;
          mem_dat_o <= rmw_merge(rmw_q, dat_q, size_q, adr_q[2:0]);
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_o <= 1'b0;
          resp_err_o   <= 1'b0;
          resp_dat_o   <= '0;
          req_ready_o  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_access.sv
// Scoreboard bench for wb_mem_access against a one-cycle-ack RAM model with error and hang modes.
module tb_wb_mem_access;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic [AW-1:0] req_adr = '0;
  logic [63:0]   req_dat = '0;
  logic          req_ready, resp_valid, resp_err;
  logic [63:0]   resp_dat;
  logic [AW-1:0] mem_adr;
  logic [63:0]   mem_dat_o, mem_dat_i;
  logic          mem_we, mem_stb, mem_ack, mem_err;

  wb_mem_access #(.ADR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_adr_i(req_adr), .req_dat_i(req_dat),
    .resp_valid_o(resp_valid), .resp_dat_o(resp_dat), .resp_err_o(resp_err),
    .mem_adr_o(mem_adr), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
    .mem_we_o(mem_we), .mem_stb_o(mem_stb), .mem_ack_i(mem_ack), .mem_err_i(mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM slave: 16 words at 0x00-0x7F, err beyond, ack registered one cycle after stb.
  logic [63:0] ram [16];
  logic        hang = 1'b0;
  logic        ack_q = 1'b0, err_q = 1'b0;
  logic [63:0] rd_q = '0;
  int n_wr = 0, n_rd = 0, n_rise = 0, n_stb_hi = 0, low_run = 0, last_gap = 0;
  logic stb_prev = 1'b0;
  assign mem_ack   = ack_q;
  assign mem_err   = err_q;
  assign mem_dat_i = rd_q;

  initial for (int i = 0; i < 16; i++) ram[i] = 64'd0;

  always @(posedge clk) begin
    ack_q <= 1'b0;
    err_q <= 1'b0;
    if (mem_stb && !ack_q && !err_q && !hang) begin
      if (mem_adr < 32'h80) begin
        ack_q <= 1'b1;
        if (mem_we) begin
          ram[mem_adr[6:3]] <= mem_dat_o;
          n_wr <= n_wr + 1;
        end else begin
          rd_q <= ram[mem_adr[6:3]];
          n_rd <= n_rd + 1;
        end
      end else begin
        err_q <= 1'b1;
      end
    end
    stb_prev <= mem_stb;
    if (mem_stb) n_stb_hi <= n_stb_hi + 1;
    if (mem_stb && !stb_prev) begin
      n_rise   <= n_rise + 1;
      last_gap <= low_run;
    end
    low_run <= mem_stb ? 0 : low_run + 1;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        err;
    logic [63:0] dat;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  // Monitor: the accept cycle counts as cycle 1 of the latency.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_err"}, 64'(resp_err), 64'(e.err));
        chk({e.name, "_dat"}, resp_dat, e.dat);
        chk({e.name, "_lat"}, 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  task automatic do_req(input string name, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [AW-1:0] adr, input logic [63:0] dat,
                        input logic exp_err, input logic [63:0] exp_dat, input int exp_lat);
    exp_t e;
    int   bound;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn; req_adr = adr; req_dat = dat;
    bound = 0;
    while (!req_ready && bound < 50) begin @(negedge clk); bound++; end
    if (!req_ready) begin
      chk({name, "_accept_timeout"}, 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    e.name = name; e.err = exp_err; e.dat = exp_dat; e.lat = exp_lat; e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    bound = 0;
    while (sb.size() != 0 && bound < 60) begin @(negedge clk); bound++; end
    if (sb.size() != 0) begin
      chk({name, "_resp_timeout"}, 64'd0, 64'd1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  int wr0, rd0, rise0, hi0;
  task automatic snap();
    wr0 = n_wr; rd0 = n_rd; rise0 = n_rise; hi0 = n_stb_hi;
  endtask

  logic [63:0] exp_sbyte, exp_sword;

  initial begin
`ifdef MEM_ACCESS_SIGN_EXT_EN
    exp_sbyte = 64'hFFFF_FFFF_FFFF_FFAB;
    exp_sword = 64'hFFFF_FFFF_CAFE_BABE;
`else
    exp_sbyte = 64'h0000_0000_0000_00AB;
    exp_sword = 64'h0000_0000_CAFE_BABE;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_stb", 64'(mem_stb), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_dat", resp_dat, 64'd0);
    chk("rst_adr", 64'(mem_adr), 64'd0);

    snap();
    do_req("st_dword", 1'b1, 2'd3, 1'b0, 32'h10, 64'h1122_3344_5566_7788, 1'b0, 64'd0, 4);
    chk("st_dword_writes", 64'(n_wr - wr0), 64'd1);
    chk("st_dword_reads", 64'(n_rd - rd0), 64'd0);
    chk("st_dword_ram", ram[2], 64'h1122_3344_5566_7788);

    snap();
    do_req("ld_dword", 1'b0, 2'd3, 1'b0, 32'h10, 64'd0, 1'b0, 64'h1122_3344_5566_7788, 4);
    chk("ld_dword_reads", 64'(n_rd - rd0), 64'd1);
    chk("ld_dword_writes", 64'(n_wr - wr0), 64'd0);

    do_req("ld_half12", 1'b0, 2'd1, 1'b0, 32'h12, 64'd0, 1'b0, 64'h0000_0000_0000_5566, 4);

    snap();
    do_req("ld_half_mis", 1'b0, 2'd1, 1'b0, 32'h11, 64'd0, 1'b1, 64'd0, 2);
    chk("ld_half_mis_stb", 64'(n_rise - rise0), 64'd0);

    snap();
    do_req("st_byte", 1'b1, 2'd0, 1'b0, 32'h13, 64'hDEAD_BEEF_CAFE_12AB, 1'b0, 64'd0, 7);
    chk("st_byte_ram", ram[2], 64'h1122_3344_AB66_7788);
    chk("st_byte_reads", 64'(n_rd - rd0), 64'd1);
    chk("st_byte_writes", 64'(n_wr - wr0), 64'd1);
    chk("st_byte_pulses", 64'(n_rise - rise0), 64'd2);
    chk("st_byte_gap", 64'(last_gap), 64'd1);

    do_req("ld_byte_s", 1'b0, 2'd0, 1'b1, 32'h13, 64'd0, 1'b0, exp_sbyte, 4);
    do_req("ld_byte_u", 1'b0, 2'd0, 1'b0, 32'h13, 64'd0, 1'b0, 64'h0000_0000_0000_00AB, 4);

    do_req("st_word", 1'b1, 2'd2, 1'b0, 32'h24, 64'h0000_0000_CAFE_BABE, 1'b0, 64'd0, 7);
    chk("st_word_ram", ram[4], 64'hCAFE_BABE_0000_0000);
    do_req("ld_word_s", 1'b0, 2'd2, 1'b1, 32'h24, 64'd0, 1'b0, exp_sword, 4);

    do_req("ld_slv_err", 1'b0, 2'd3, 1'b0, 32'h100, 64'd0, 1'b1, 64'd0, 4);
    snap();
    do_req("st_slv_err", 1'b1, 2'd0, 1'b0, 32'h101, 64'h55, 1'b1, 64'd0, 4);
    chk("st_slv_err_writes", 64'(n_wr - wr0), 64'd0);
    chk("st_slv_err_pulses", 64'(n_rise - rise0), 64'd1);

    hang = 1'b1;
    snap();
    do_req("timeout", 1'b0, 2'd3, 1'b0, 32'h18, 64'd0, 1'b1, 64'd0, 10);
    chk("timeout_stb_cycles", 64'(n_stb_hi - hi0), 64'd8);

    // Reset while BUS_A is stalled: no response may follow.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_adr = 32'h18;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busa_stb_before_rst", 64'(mem_stb), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_stb", 64'(mem_stb), 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    hang = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    do_req("ld_after_rst", 1'b0, 2'd3, 1'b0, 32'h10, 64'd0, 1'b0, 64'h1122_3344_AB66_7788, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang, expected finish");
    $fatal(1, "global timeout");
  end
endmodule
